sound_wave_regs: RTL and testbench

SOUND_WAVE_REGS -- requirements
Module: sound_wave_regs

---
 rtl/sound_wave_regs.sv | 121 ++++++++++++
 tb/tb_sound_wave_regs.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/sound_wave_regs.sv
// Wave channel (channel 3) CPU register block: NR30-NR34 and the 16-byte wave RAM.
// Optional feature: define SOUND_WAVE_RAM_LOCK_EN to redirect CPU wave RAM access
// to the byte the channel is currently playing while the channel is running.
module sound_wave_regs (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] a,
  input  logic [7:0]  din,
  input  logic        wr,
  input  logic        rd,
  output logic [7:0]  dout,
  input  logic        apu_on,
  input  logic        chan_enable,
  input  logic [3:0]  wave_a,
  output logic [7:0]  wave_d,
  output logic        on,
  output logic [1:0]  volume,
  output logic [7:0]  length,
  output logic [10:0] frequency,
  output logic        single,
  output logic        start
);

  localparam int unsigned RAM_DEPTH = 16;
  localparam int unsigned DATA_W    = 8;

  localparam logic [15:0] ADDR_NR30 = 16'hFF1A;
  localparam logic [15:0] ADDR_NR31 = 16'hFF1B;
  localparam logic [15:0] ADDR_NR32 = 16'hFF1C;
  localparam logic [15:0] ADDR_NR33 = 16'hFF1D;
  localparam logic [15:0] ADDR_NR34 = 16'hFF1E;

  logic [DATA_W-1:0] ram [RAM_DEPTH];
  logic              sel_wave;
  logic              wave_lock;
  logic [3:0]        wave_idx;
  logic              trigger;
  logic [DATA_W-1:0] rd_data;

  assign sel_wave = (a[15:4] == 12'hFF3);

`ifdef SOUND_WAVE_RAM_LOCK_EN
  // While the channel plays, the CPU only reaches the byte being played
  assign wave_lock = on & chan_enable;
`else
  logic unused_chan_enable;
  assign unused_chan_enable = chan_enable;
  assign wave_lock          = 1'b0;
`endif

  assign wave_idx = wave_lock ? wave_a : a[3:0];

  // Channel-side wave RAM read port, write-through visible from the write edge
  assign wave_d = ram[wave_a];

  // A trigger only counts when the channel DAC is on and the APU is powered
  assign trigger = wr & (a == ADDR_NR34) & din[7] & on & apu_on;

  // CPU read data mux; unused bits read back as 1
  always_comb begin
    rd_data = 8'hFF;
    case (a)
      ADDR_NR30: rd_data = {on, 7'h7F};
      ADDR_NR31: rd_data = 8'hFF;
      ADDR_NR32: rd_data = {1'b1, volume, 5'h1F};
      ADDR_NR33: rd_data = 8'hFF;
      ADDR_NR34: rd_data = {1'b1, single, 6'h3F};
      default:   if (sel_wave) rd_data = ram[wave_idx];
    endcase
  end

  // NR30-NR34 state and trigger pulse; held cleared while the APU is off
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      on        <= 1'b0;
      volume    <= 2'd0;
      length    <= 8'd0;
      frequency <= 11'd0;
      single    <= 1'b0;
      start     <= 1'b0;
    end else if (!apu_on) begin
      on        <= 1'b0;
      volume    <= 2'd0;
      length    <= 8'd0;
      frequency <= 11'd0;
      single    <= 1'b0;
      start     <= 1'b0;
    end else begin
      start <= trigger;
      if (wr) begin
        case (a)
          ADDR_NR30: on              <= din[7];
          ADDR_NR31: length          <= din;
          ADDR_NR32: volume          <= din[6:5];
          ADDR_NR33: frequency[7:0]  <= din;
          ADDR_NR34: begin
            frequency[10:8] <= din[2:0];
            single          <= din[6];
          end
          default: ;
        endcase
      end
    end
  end

  // Wave RAM CPU writes; accessible regardless of APU power
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(RAM_DEPTH); i++) ram[i] <= '0;
    end else if (wr && sel_wave) begin
      ram[wave_idx] <= din;
    end
  end

  // Registered read data; idle and write cycles return FF
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dout <= 8'hFF;
    else        dout <= (rd && !wr) ? rd_data : 8'hFF;
  end

endmodule

// File: tb/tb_sound_wave_regs.sv
// Directed, table-driven bench for sound_wave_regs.
module tb_sound_wave_regs;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] a;
  logic [7:0]  din;
  logic        wr, rd;
  logic [7:0]  dout;
  logic        apu_on, chan_enable;
  logic [3:0]  wave_a;
  logic [7:0]  wave_d;
  logic        on;
  logic [1:0]  volume;
  logic [7:0]  length;
  logic [10:0] frequency;
  logic        single, start;

  int n_vec = 0;
  int n_err = 0;

  sound_wave_regs dut (
    .clk(clk), .rst_n(rst_n), .a(a), .din(din), .wr(wr), .rd(rd), .dout(dout),
    .apu_on(apu_on), .chan_enable(chan_enable), .wave_a(wave_a), .wave_d(wave_d),
    .on(on), .volume(volume), .length(length), .frequency(frequency),
    .single(single), .start(start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr, rd;
    logic [15:0] a;
    logic [7:0]  din;
    logic        apu;
    logic [3:0]  wa;
    logic [7:0]  e_dout;
    logic        e_on;
    logic [1:0]  e_vol;
    logic [7:0]  e_len;
    logic [10:0] e_freq;
    logic        e_single, e_start;
    logic [7:0]  e_wd;
  } vec_t;

  localparam int NV = 26;
  vec_t tv [NV];

  function automatic vec_t mk(input logic w, input logic r, input logic [15:0] ad,
                              input logic [7:0] d, input logic ap, input logic [3:0] wa,
                              input logic [7:0] edo, input logic eon, input logic [1:0] evo,
                              input logic [7:0] ele, input logic [10:0] efr,
                              input logic esi, input logic est, input logic [7:0] ewd);
    vec_t v;
    v.wr = w; v.rd = r; v.a = ad; v.din = d; v.apu = ap; v.wa = wa;
    v.e_dout = edo; v.e_on = eon; v.e_vol = evo; v.e_len = ele; v.e_freq = efr;
    v.e_single = esi; v.e_start = est; v.e_wd = ewd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic w, input logic r, input logic [15:0] ad, input logic [7:0] d);
    wr = w; rd = r; a = ad; din = d;
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    // {wr,rd,a,din,apu_on,wave_a} -> {dout,on,volume,length,frequency,single,start,wave_d}
    tv[0]  = mk(0,1,16'hFF1A,8'h00,1,4'h0, 8'h7F,0,2'd0,8'h00,11'h000,0,0,8'h00);
    tv[1]  = mk(0,1,16'hFF1C,8'h00,1,4'h0, 8'h9F,0,2'd0,8'h00,11'h000,0,0,8'h00);
    tv[2]  = mk(0,1,16'hFF1E,8'h00,1,4'h0, 8'hBF,0,2'd0,8'h00,11'h000,0,0,8'h00);
    tv[3]  = mk(0,1,16'hFF35,8'h00,1,4'h0, 8'h00,0,2'd0,8'h00,11'h000,0,0,8'h00);
    tv[4]  = mk(0,0,16'h0000,8'h00,1,4'h0, 8'hFF,0,2'd0,8'h00,11'h000,0,0,8'h00);
    tv[5]  = mk(1,0,16'hFF1A,8'h80,1,4'h0, 8'hFF,1,2'd0,8'h00,11'h000,0,0,8'h00);
    tv[6]  = mk(1,0,16'hFF1D,8'h34,1,4'h0, 8'hFF,1,2'd0,8'h00,11'h034,0,0,8'h00);
    tv[7]  = mk(1,0,16'hFF1E,8'hC5,1,4'h0, 8'hFF,1,2'd0,8'h00,11'h534,1,1,8'h00);
    tv[8]  = mk(0,0,16'h0000,8'h00,1,4'h0, 8'hFF,1,2'd0,8'h00,11'h534,1,0,8'h00);
    tv[9]  = mk(0,1,16'hFF1C,8'h00,1,4'h0, 8'h9F,1,2'd0,8'h00,11'h534,1,0,8'h00);
    tv[10] = mk(1,0,16'hFF1C,8'h20,1,4'h0, 8'hFF,1,2'd1,8'h00,11'h534,1,0,8'h00);
    tv[11] = mk(0,1,16'hFF1C,8'h00,1,4'h0, 8'hBF,1,2'd1,8'h00,11'h534,1,0,8'h00);
    tv[12] = mk(1,0,16'hFF1B,8'hAB,1,4'h0, 8'hFF,1,2'd1,8'hAB,11'h534,1,0,8'h00);
    tv[13] = mk(1,1,16'hFF1C,8'h40,1,4'h0, 8'hFF,1,2'd2,8'hAB,11'h534,1,0,8'h00);
    tv[14] = mk(1,0,16'hFF1A,8'h00,1,4'h0, 8'hFF,0,2'd2,8'hAB,11'h534,1,0,8'h00);
    tv[15] = mk(1,0,16'hFF1E,8'h80,1,4'h0, 8'hFF,0,2'd2,8'hAB,11'h034,0,0,8'h00);
    tv[16] = mk(1,0,16'hFF37,8'hA5,1,4'h7, 8'hFF,0,2'd2,8'hAB,11'h034,0,0,8'hA5);
    tv[17] = mk(0,0,16'h0000,8'h00,1,4'h6, 8'hFF,0,2'd2,8'hAB,11'h034,0,0,8'h00);
    tv[18] = mk(0,1,16'hFF37,8'h00,1,4'h7, 8'hA5,0,2'd2,8'hAB,11'h034,0,0,8'hA5);
    tv[19] = mk(1,1,16'hFF20,8'h55,1,4'h0, 8'hFF,0,2'd2,8'hAB,11'h034,0,0,8'h00);
    tv[20] = mk(0,1,16'hFF40,8'h00,1,4'h0, 8'hFF,0,2'd2,8'hAB,11'h034,0,0,8'h00);
    tv[21] = mk(0,0,16'h0000,8'h00,0,4'h0, 8'hFF,0,2'd0,8'h00,11'h000,0,0,8'h00);
    tv[22] = mk(1,0,16'hFF1C,8'h60,0,4'h0, 8'hFF,0,2'd0,8'h00,11'h000,0,0,8'h00);
    tv[23] = mk(1,0,16'hFF30,8'h12,0,4'h0, 8'hFF,0,2'd0,8'h00,11'h000,0,0,8'h12);
    tv[24] = mk(0,1,16'hFF30,8'h00,0,4'h0, 8'h12,0,2'd0,8'h00,11'h000,0,0,8'h12);
    tv[25] = mk(0,1,16'hFF1E,8'h00,1,4'h0, 8'hBF,0,2'd0,8'h00,11'h000,0,0,8'h12);

    rst_n = 1'b0; a = '0; din = '0; wr = 1'b0; rd = 1'b0;
    apu_on = 1'b1; chan_enable = 1'b0; wave_a = 4'h0;
    #12;
    chk("reset_outputs", 64'({dout, on, volume, length, frequency, single, start, wave_d}),
        64'({8'hFF, 1'b0, 2'd0, 8'h00, 11'h000, 1'b0, 1'b0, 8'h00}));
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      apu_on = tv[i].apu; wave_a = tv[i].wa;
      cyc(tv[i].wr, tv[i].rd, tv[i].a, tv[i].din);
      chk($sformatf("vec%0d", i),
          64'({dout, on, volume, length, frequency, single, start, wave_d}),
          64'({tv[i].e_dout, tv[i].e_on, tv[i].e_vol, tv[i].e_len, tv[i].e_freq,
               tv[i].e_single, tv[i].e_start, tv[i].e_wd}));
    end

    // Channel sees old byte until the write edge, new byte from it
    wave_a = 4'h7; wr = 1'b1; a = 16'hFF37; din = 8'h5A; #1;
    chk("wave_d_before_edge", 64'(wave_d), 64'(8'hA5));
    @(posedge clk); #1;
    chk("wave_d_after_edge", 64'(wave_d), 64'(8'h5A));

    // Trigger on the same edge the APU powers down is cancelled
    cyc(1, 0, 16'hFF1A, 8'h80);
    apu_on = 1'b0;
    cyc(1, 0, 16'hFF1E, 8'h80);
    chk("apu_off_cancels_start", 64'({start, on}), 64'(2'b00));
    apu_on = 1'b1;

    // Trigger then NR30 clear: one-cycle pulse, then channel off
    cyc(1, 0, 16'hFF1A, 8'h80);
    cyc(1, 0, 16'hFF1E, 8'h87);
    chk("trigger_pulse", 64'({start, frequency}), 64'({1'b1, 11'h700}));
    cyc(1, 0, 16'hFF1A, 8'h00);
    chk("dac_off_clears", 64'({start, on}), 64'(2'b00));

    // Reset during a start pulse drops it at once
    cyc(1, 0, 16'hFF1A, 8'h80);
    cyc(1, 0, 16'hFF1E, 8'h80);
    chk("trigger_pre_reset", 64'(start), 64'(1'b1));
    wr = 1'b0; #2;
    rst_n = 1'b0; #1;
    chk("async_reset", 64'({start, on, dout, wave_d}), 64'({1'b0, 1'b0, 8'hFF, 8'h00}));
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(1, 0, 16'hFF1A, 8'h80);
    chk("first_write_after_reset", 64'({on, start}), 64'(2'b10));

    // Wave RAM access while the channel is running
    cyc(1, 0, 16'hFF3C, 8'h77);
    cyc(1, 0, 16'hFF33, 8'h5A);
    chan_enable = 1'b1; wave_a = 4'h3;
    cyc(0, 1, 16'hFF3C, 8'h00);
`ifdef SOUND_WAVE_RAM_LOCK_EN
    chk("lock_read", 64'(dout), 64'(8'h5A));
    cyc(1, 0, 16'hFF3C, 8'h11);
    chk("lock_write_wave_d", 64'(wave_d), 64'(8'h11));
    chan_enable = 1'b0;
    cyc(0, 1, 16'hFF3C, 8'h00);
    chk("lock_other_unchanged", 64'(dout), 64'(8'h77));
`else
    chk("exact_read", 64'(dout), 64'(8'h77));
    cyc(1, 0, 16'hFF3C, 8'h11);
    chk("exact_write_wave_d", 64'(wave_d), 64'(8'h5A));
    cyc(0, 1, 16'hFF3C, 8'h00);
    chk("exact_write_readback", 64'(dout), 64'(8'h11));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
